// File: rtl/posit_pkg.sv
// Shared constants and FSM encoding for the 32-bit, es=3 posit encoder.
package posit_pkg;

    localparam int N  = 32;
    localparam int ES = 3;

    localparam logic [N-1:0] NAR    = 32'h8000_0000;
    localparam logic [N-1:0] MAXPOS = 32'h7FFF_FFFF;
    localparam logic [N-1:0] MINPOS = 32'h0000_0001;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        BUILD   = 3'd2,
        NEGATE  = 3'd3,
        HOLD    = 3'd4
    } posit_state_e;

endpackage

// File: rtl/posit_regime_pack.sv
// Combinational assembly of the 31-bit posit body: regime run, terminator,
// exponent and fraction, with saturation to maxpos/minpos.
module posit_regime_pack
    import posit_pkg::*;
(
    input  logic [5:0]    k,
    input  logic [ES-1:0] exp_f,
    input  logic [N-1:0]  mant,
    output logic [N-2:0]  body
);

    logic       fill;
    logic [5:0] run;
    logic [67:0] w;
    logic [67:0] shifted;

    // The run of fill bits sits above a terminator; shifting the whole string
    // right by (5 + run) leaves exactly the top 31 bits of the body.
    always_comb begin
        fill    = ~k[5];
        run     = k[5] ? (6'd0 - k) : (k + 6'd1);
        w       = {{32{fill}}, ~fill, exp_f, mant};
        shifted = w >> (7'd5 + {1'b0, run});
        body    = shifted[N-2:0];
        if (!k[5] && (k >= 6'd30)) begin
            body = MAXPOS[N-2:0];
        end else if (k[5] && (k <= 6'd33)) begin
            body = MINPOS[N-2:0];
        end
    end

endmodule

// File: rtl/posit_encoder.sv
// Sequential posit encoder: captures a rounded result, builds the body,
// applies sign/special cases and holds the word until acknowledged.
module posit_encoder
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_done,
    input  logic [N-1:0]  mantissa_in,
    input  logic [5:0]    k_in,
    input  logic [ES-1:0] exp_in,
    input  logic          sign_in,
    input  logic          zero_in,
    input  logic          nar_in,
    output logic          recieved,
    output logic [N-1:0]  posit_out,
    output logic          out_valid,
    input  logic          out_ack
);

    posit_state_e  state_q, state_d;
    logic [5:0]    k_q, k_d;
    logic [ES-1:0] exp_q, exp_d;
    logic [N-1:0]  mant_q, mant_d;
    logic          sign_q, sign_d;
    logic          zero_q, zero_d;
    logic          nar_q, nar_d;
    logic [N-2:0]  body_q, body_d;
    logic [N-1:0]  posit_out_q, posit_out_d;
    logic [N-2:0]  body_w;
    logic [N-1:0]  word_w;

    posit_regime_pack u_pack (
        .k     (k_q),
        .exp_f (exp_q),
        .mant  (mant_q),
        .body  (body_w)
    );

    // NaR outranks zero; both outrank the signed body.
    always_comb begin
        word_w = {1'b0, body_q};
        if (nar_q) begin
            word_w = NAR;
        end else if (zero_q) begin
            word_w = '0;
        end else if (sign_q) begin
            word_w = {N{1'b0}} - {1'b0, body_q};
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        nar_d       = nar_q;
        body_d      = body_q;
        posit_out_d = posit_out_q;
        case (state_q)
            IDLE: begin
                if (in_done) state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = BUILD;
                k_d     = k_in;
                exp_d   = exp_in;
                mant_d  = mantissa_in;
                sign_d  = sign_in;
                zero_d  = zero_in;
                nar_d   = nar_in;
            end
            BUILD: begin
                state_d = NEGATE;
                body_d  = body_w;
            end
            NEGATE: begin
                state_d     = HOLD;
                posit_out_d = word_w;
            end
            HOLD: begin
                if (out_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            exp_q       <= '0;
            mant_q      <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            nar_q       <= 1'b0;
            body_q      <= '0;
            posit_out_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            nar_q       <= nar_d;
            body_q      <= body_d;
            posit_out_q <= posit_out_d;
        end
    end

    assign recieved  = (state_q == CAPTURE);
    assign out_valid = (state_q == HOLD);
    assign posit_out = posit_out_q;

endmodule

// File: tb/tb_posit_encoder.sv
// Directed bench for posit_encoder: encoding vectors, saturation, specials,
// handshake timing and mid-operation reset.
module tb_posit_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_done;
    logic [31:0] mantissa_in;
    logic [5:0]  k_in;
    logic [2:0]  exp_in;
    logic        sign_in;
    logic        zero_in;
    logic        nar_in;
    logic        recieved;
    logic [31:0] posit_out;
    logic        out_valid;
    logic        out_ack;

    int n_vec;
    int n_miss;
    int rcv_cnt;

    posit_encoder #(.N(32), .ES(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_done     (in_done),
        .mantissa_in (mantissa_in),
        .k_in        (k_in),
        .exp_in      (exp_in),
        .sign_in     (sign_in),
        .zero_in     (zero_in),
        .nar_in      (nar_in),
        .recieved    (recieved),
        .posit_out   (posit_out),
        .out_valid   (out_valid),
        .out_ack     (out_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (recieved) rcv_cnt = rcv_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_vec = n_vec + 1;
        if (got !== exp_v) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp_v);
        end
    endtask

    task automatic set_data(input int k, input logic [2:0] e, input logic [31:0] m,
                            input logic s, input logic z, input logic n);
        logic [31:0] kv;
        kv          = k;
        k_in        = kv[5:0];
        exp_in      = e;
        mantissa_in = m;
        sign_in     = s;
        zero_in     = z;
        nar_in      = n;
    endtask

    // Presents one result with in_done held for `hold` edges, checks latency,
    // the single consume pulse and the encoded word; optionally acknowledges.
    task automatic run_vec(input string tag, input int k, input logic [2:0] e,
                           input logic [31:0] m, input logic s, input logic z,
                           input logic n, input int hold, input logic [31:0] exp_w,
                           input bit do_ack);
        int lat;
        set_data(k, e, m, s, z, n);
        rcv_cnt = 0;
        in_done = 1'b1;
        lat     = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat = lat + 1;
            if (lat == hold) in_done = 1'b0;
            if (lat == 2) begin
                set_data($urandom_range(0, 63), 3'($urandom_range(0, 7)), $urandom,
                         1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
        end
        in_done = 1'b0;
        check_eq({tag, "_latency"}, lat, 32'd4);
        check_eq({tag, "_word"}, posit_out, exp_w);
        check_eq({tag, "_pulses"}, rcv_cnt, 32'd1);
        if (do_ack) begin
            out_ack = 1'b1;
            tick();
            out_ack = 1'b0;
            check_eq({tag, "_ack_drop"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        int  stable_bad;
        int  lat;
        logic [31:0] held;
        n_vec   = 0;
        n_miss  = 0;
        rcv_cnt = 0;
        rst_n   = 1'b0;
        in_done = 1'b0;
        out_ack = 1'b0;
        set_data(0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_recv", {31'd0, recieved}, 32'd0);
        check_eq("rst_word", posit_out, 32'd0);
        rst_n = 1'b1;
        tick();

        run_vec("k0_pos",     0,   3'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2, 32'h4000_0000, 1);
        run_vec("k0_neg",     0,   3'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2, 32'hC000_0000, 1);
        run_vec("km1_e7",     -1,  3'd7, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2, 32'h3E00_0000, 1);
        run_vec("k2_e1",      2,   3'd1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2, 32'h7100_0000, 1);
        run_vec("k1_neg",     1,   3'd3, 32'hA000_0000, 1'b1, 1'b0, 1'b0, 2, 32'h98C0_0000, 1);
        run_vec("km3_trunc",  -3,  3'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 2, 32'h0AFF_FFFF, 1);
        run_vec("k31_sat",    31,  3'd5, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 2, 32'h7FFF_FFFF, 1);
        run_vec("k30_sat",    30,  3'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2, 32'h7FFF_FFFF, 1);
        run_vec("k29",        29,  3'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2, 32'h7FFF_FFFE, 1);
        run_vec("k28_e7",     28,  3'd7, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2, 32'h7FFF_FFFD, 1);
        run_vec("km32",       -32, 3'd6, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 2, 32'h0000_0001, 1);
        run_vec("km32_neg",   -32, 3'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2, 32'hFFFF_FFFF, 1);
        run_vec("km31",       -31, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2, 32'h0000_0001, 1);
        run_vec("zero",       5,   3'd3, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 2, 32'h0000_0000, 1);
        run_vec("nar_zero",   0,   3'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 2, 32'h8000_0000, 1);
        run_vec("nar_sign",   -4,  3'd1, 32'h4000_0000, 1'b1, 1'b0, 1'b1, 2, 32'h8000_0000, 1);

        // in_done held three cycles, then ack withheld for ten cycles
        run_vec("hold3", 2, 3'd1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 3, 32'h7100_0000, 0);
        held = posit_out;
        stable_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || posit_out !== held) stable_bad = stable_bad + 1;
        end
        check_eq("stall_stable", stable_bad, 32'd0);
        check_eq("stall_pulses", rcv_cnt, 32'd1);

        // ack and in_done together: IDLE next cycle, capture the cycle after
        set_data(-1, 3'd7, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        in_done = 1'b1;
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check_eq("ackdone_valid", {31'd0, out_valid}, 32'd0);
        check_eq("ackdone_idle_recv", {31'd0, recieved}, 32'd0);
        tick();
        check_eq("ackdone_capture", {31'd0, recieved}, 32'd1);
        in_done = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat = lat + 1;
        end
        check_eq("ackdone_lat", lat, 32'd3);
        check_eq("ackdone_word", posit_out, 32'hC200_0000);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;

        // out_ack outside HOLD is ignored
        out_ack = 1'b1;
        tick();
        tick();
        out_ack = 1'b0;
        check_eq("stray_ack_valid", {31'd0, out_valid}, 32'd0);
        run_vec("after_stray", 0, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2, 32'h4000_0000, 1);

        // reset pulsed during BUILD abandons the result
        set_data(2, 3'd1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        in_done = 1'b1;
        tick();
        tick();
        in_done = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_word", posit_out, 32'd0);
        tick();
        rst_n = 1'b1;
        stable_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid || recieved) stable_bad = stable_bad + 1;
        end
        check_eq("midrst_quiet", stable_bad, 32'd0);
        run_vec("post_rst", -1, 3'd7, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2, 32'h3E00_0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
